// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types and defaults for the bomb manager
// Purpose: slot state encoding, tile/owner types and the default fuse length
//          shared by bomb_manager and bomb_slot_bank.
// Ports:   none (package).
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2,
    FIRING  = 2'd3
  } slot_state_t;

  // Tile index y*16+x.
  typedef logic [7:0] coord_t;

  typedef logic owner_t;
  localparam owner_t OWNER_P1 = 1'b0;
  localparam owner_t OWNER_P2 = 1'b1;

  localparam int DEFAULT_FUSE_TICKS = 3;

endpackage

// File: rtl/bomb_slot_bank.sv
// rtl/bomb_slot_bank.sv - per-player bomb slots, fuses and slot encoders
// Purpose: holds one player's bomb slots. Loads the lowest IDLE slot on
//          accept, counts fuses down on tick, hands the lowest EXPIRED slot
//          to the output arbiter and frees the FIRING slot on handshake.
// Ports:   clk, rst          clock, async active-high reset
//          tick              game-tick strobe
//          accept/acc_coord  place a bomb in the lowest free slot
//          fire              move the lowest EXPIRED slot to FIRING
//          done              FIRING slot returns to IDLE
//          q0/q1_coord       query tiles for duplicate detection
//          match0/match1     per-slot live-coordinate match vectors
//          has_free          an IDLE slot exists
//          has_expired       an EXPIRED slot exists; exp_coord is its tile
//          live_count        number of non-IDLE slots
module bomb_slot_bank
  import bomb_pkg::*;
#(
  parameter int SLOTS      = 5,
  parameter int FUSE_TICKS = DEFAULT_FUSE_TICKS,
  parameter int FUSE_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             accept,
  input  logic [7:0]       acc_coord,
  input  logic             fire,
  input  logic             done,
  input  logic [7:0]       q0_coord,
  input  logic [7:0]       q1_coord,
  output logic [SLOTS-1:0] match0,
  output logic [SLOTS-1:0] match1,
  output logic             has_free,
  output logic             has_expired,
  output logic [7:0]       exp_coord,
  output logic [2:0]       live_count
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  slot_state_t       state [SLOTS];
  coord_t            coord [SLOTS];
  logic [FUSE_W-1:0] fuse  [SLOTS];

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] exp_idx;

  // Lowest-index wins: scan downward so the last hit is the lowest.
  always_comb begin
    free_idx    = '0;
    has_free    = 1'b0;
    exp_idx     = '0;
    has_expired = 1'b0;
    live_count  = 3'd0;
    match0      = '0;
    match1      = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (state[i] == IDLE) begin
        free_idx = IDX_W'(i);
        has_free = 1'b1;
      end
      if (state[i] == EXPIRED) begin
        exp_idx     = IDX_W'(i);
        has_expired = 1'b1;
      end
      if (state[i] != IDLE) begin
        live_count = live_count + 3'd1;
        match0[i]  = (coord[i] == q0_coord);
        match1[i]  = (coord[i] == q1_coord);
      end
    end
  end

  assign exp_coord = coord[exp_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        state[i] <= IDLE;
        coord[i] <= '0;
        fuse[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        case (state[i])
          IDLE: begin
            if (accept && free_idx == IDX_W'(i)) begin
              state[i] <= ARMED;
              coord[i] <= acc_coord;
              fuse[i]  <= FUSE_W'(FUSE_TICKS);
            end
          end
          ARMED: begin
            if (tick) begin
              fuse[i] <= fuse[i] - FUSE_W'(1);
              if (fuse[i] <= FUSE_W'(1)) state[i] <= EXPIRED;
            end
          end
          EXPIRED: begin
            if (fire && exp_idx == IDX_W'(i)) state[i] <= FIRING;
          end
          FIRING: begin
            // Only one slot system-wide can be FIRING, so done needs no index.
            if (done) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/bomb_manager.sv
// rtl/bomb_manager.sv - bomb placement, fuse tracking and explosion events
// Purpose: edge-detects player bomb requests, resolves duplicates and
//          same-tile conflicts, tracks fuses in two slot banks and issues
//          explosion events through a one-entry valid/ready output register.
// Ports:   clk, rst                     clock, async active-high reset
//          tick                         game-tick strobe
//          p1/p2_set_bomb, _coordinate  placement requests
//          bomb_num_1/2                 live bomb count per player
//          p1/p2_reject                 one-cycle request-dropped pulse
//          explode_valid/ready          explosion event handshake
//          explode_coord/owner          tile and owner of the event
module bomb_manager
  import bomb_pkg::*;
#(
  parameter int SLOTS      = 5,
  parameter int FUSE_TICKS = DEFAULT_FUSE_TICKS,
  parameter int FUSE_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       p1_set_bomb,
  input  logic [7:0] p1_coordinate,
  input  logic       p2_set_bomb,
  input  logic [7:0] p2_coordinate,
  output logic [2:0] bomb_num_1,
  output logic [2:0] bomb_num_2,
  output logic       p1_reject,
  output logic       p2_reject,
  output logic       explode_valid,
  input  logic       explode_ready,
  output logic [7:0] explode_coord,
  output logic       explode_owner
);

  logic   p1_set_q, p1_set_qq, p2_set_q, p2_set_qq;
  coord_t p1_coord_q, p2_coord_q;

  logic [SLOTS-1:0] b1_m0, b1_m1, b2_m0, b2_m1;
  logic             b1_free, b2_free, b1_exp, b2_exp;
  coord_t           b1_exp_coord, b2_exp_coord;
  logic [2:0]       b1_count, b2_count;

  logic p1_rise, p2_rise, p1_ok, p2_ok;
  logic fire1, fire2, done1, done2, handshake;

  assign p1_rise = p1_set_q & ~p1_set_qq;
  assign p2_rise = p2_set_q & ~p2_set_qq;

  // A tile may hold only one live bomb across both players; on a same-cycle
  // collision player 1 wins.
  assign p1_ok = p1_rise & b1_free & ~(|b1_m0) & ~(|b2_m0);
  assign p2_ok = p2_rise & b2_free & ~(|b1_m1) & ~(|b2_m1)
               & ~(p1_ok && p1_coord_q == p2_coord_q);

  // Arbiter runs only while the output register is empty; p1 has priority.
  assign fire1     = ~explode_valid & b1_exp;
  assign fire2     = ~explode_valid & ~b1_exp & b2_exp;
  assign handshake = explode_valid & explode_ready;
  assign done1     = handshake & (explode_owner == OWNER_P1);
  assign done2     = handshake & (explode_owner == OWNER_P2);

  bomb_slot_bank #(.SLOTS(SLOTS), .FUSE_TICKS(FUSE_TICKS), .FUSE_W(FUSE_W)) u_bank_p1 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .accept     (p1_ok),
    .acc_coord  (p1_coord_q),
    .fire       (fire1),
    .done       (done1),
    .q0_coord   (p1_coord_q),
    .q1_coord   (p2_coord_q),
    .match0     (b1_m0),
    .match1     (b1_m1),
    .has_free   (b1_free),
    .has_expired(b1_exp),
    .exp_coord  (b1_exp_coord),
    .live_count (b1_count)
  );

  bomb_slot_bank #(.SLOTS(SLOTS), .FUSE_TICKS(FUSE_TICKS), .FUSE_W(FUSE_W)) u_bank_p2 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .accept     (p2_ok),
    .acc_coord  (p2_coord_q),
    .fire       (fire2),
    .done       (done2),
    .q0_coord   (p1_coord_q),
    .q1_coord   (p2_coord_q),
    .match0     (b2_m0),
    .match1     (b2_m1),
    .has_free   (b2_free),
    .has_expired(b2_exp),
    .exp_coord  (b2_exp_coord),
    .live_count (b2_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_set_q      <= 1'b0;
      p1_set_qq     <= 1'b0;
      p2_set_q      <= 1'b0;
      p2_set_qq     <= 1'b0;
      p1_coord_q    <= '0;
      p2_coord_q    <= '0;
      p1_reject     <= 1'b0;
      p2_reject     <= 1'b0;
      bomb_num_1    <= 3'd0;
      bomb_num_2    <= 3'd0;
      explode_valid <= 1'b0;
      explode_coord <= '0;
      explode_owner <= OWNER_P1;
    end else begin
      p1_set_q   <= p1_set_bomb;
      p1_set_qq  <= p1_set_q;
      p2_set_q   <= p2_set_bomb;
      p2_set_qq  <= p2_set_q;
      p1_coord_q <= p1_coordinate;
      p2_coord_q <= p2_coordinate;
      p1_reject  <= p1_rise & ~p1_ok;
      p2_reject  <= p2_rise & ~p2_ok;
      bomb_num_1 <= b1_count;
      bomb_num_2 <= b2_count;
      // The empty cycle after each handshake comes from the arbiter only
      // looking at the register once explode_valid is low.
      if (explode_valid) begin
        if (explode_ready) explode_valid <= 1'b0;
      end else if (b1_exp) begin
        explode_valid <= 1'b1;
        explode_coord <= b1_exp_coord;
        explode_owner <= OWNER_P1;
      end else if (b2_exp) begin
        explode_valid <= 1'b1;
        explode_coord <= b2_exp_coord;
        explode_owner <= OWNER_P2;
      end
    end
  end

endmodule

// File: tb/tb_bomb_manager.sv
// tb/tb_bomb_manager.sv - directed self-checking bench for bomb_manager
module tb_bomb_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       p1_set_bomb = 1'b0;
  logic [7:0] p1_coordinate = 8'h00;
  logic       p2_set_bomb = 1'b0;
  logic [7:0] p2_coordinate = 8'h00;
  logic [2:0] bomb_num_1, bomb_num_2;
  logic       p1_reject, p2_reject;
  logic       explode_valid;
  logic       explode_ready = 1'b0;
  logic [7:0] explode_coord;
  logic       explode_owner;

  int checks = 0;
  int errors = 0;

  bomb_manager dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .p1_set_bomb  (p1_set_bomb),
    .p1_coordinate(p1_coordinate),
    .p2_set_bomb  (p2_set_bomb),
    .p2_coordinate(p2_coordinate),
    .bomb_num_1   (bomb_num_1),
    .bomb_num_2   (bomb_num_2),
    .p1_reject    (p1_reject),
    .p2_reject    (p2_reject),
    .explode_valid(explode_valid),
    .explode_ready(explode_ready),
    .explode_coord(explode_coord),
    .explode_owner(explode_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // Single-cycle request pulses; either player may be left out.
  task automatic req(input logic do1, input logic [7:0] c1, input logic do2, input logic [7:0] c2);
    p1_coordinate = c1;
    p2_coordinate = c2;
    p1_set_bomb   = do1;
    p2_set_bomb   = do2;
    cyc();
    p1_set_bomb = 1'b0;
    p2_set_bomb = 1'b0;
    cyc();
  endtask

  task automatic drain();
    pulse_tick(3);
    explode_ready = 1'b1;
    repeat (30) cyc();
    explode_ready = 1'b0;
    cyc();
    check("drain_num1", bomb_num_1, 0);
    check("drain_num2", bomb_num_2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_rej;
    logic stable;

    repeat (3) cyc();
    check("rst_num1", bomb_num_1, 0);
    check("rst_num2", bomb_num_2, 0);
    check("rst_rej1", p1_reject, 0);
    check("rst_rej2", p2_reject, 0);
    check("rst_valid", explode_valid, 0);
    check("rst_coord", explode_coord, 0);
    check("rst_owner", explode_owner, 0);
    rst = 1'b0;
    cyc();

    // Single bomb lifecycle
    p1_coordinate = 8'h12;
    p1_set_bomb = 1'b1;
    cyc();                               // after E
    p1_set_bomb = 1'b0;
    check("life_num_e", bomb_num_1, 0);
    cyc();                               // after E+1
    check("life_rej", p1_reject, 0);
    check("life_num_e1", bomb_num_1, 0);
    cyc();                               // after E+2
    check("life_num_e2", bomb_num_1, 1);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;     // after T
    check("life_valid_t", explode_valid, 0);
    cyc();                               // after T+1
    check("life_valid", explode_valid, 1);
    check("life_coord", explode_coord, 8'h12);
    check("life_owner", explode_owner, 0);
    explode_ready = 1'b1;
    cyc();                               // after H
    explode_ready = 1'b0;
    check("life_valid_h", explode_valid, 0);
    check("life_num_h", bomb_num_1, 1);
    cyc();                               // after H+1
    check("life_num_h1", bomb_num_1, 0);
    check("life_valid_h1", explode_valid, 0);

    // Level held for 6 cycles
    seen_rej = 1'b0;
    p1_coordinate = 8'h05;
    p1_set_bomb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      seen_rej = seen_rej | p1_reject;
    end
    p1_set_bomb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      seen_rej = seen_rej | p1_reject;
    end
    check("hold_rej", seen_rej, 0);
    check("hold_num1", bomb_num_1, 1);
    drain();

    // Full: five bombs then a sixth
    for (int i = 1; i <= 5; i++) req(1'b1, 8'(i), 1'b0, 8'h00);
    cyc();
    check("full_num5", bomb_num_1, 5);
    check("full_rej_none", p1_reject, 0);
    p1_coordinate = 8'h06;
    p1_set_bomb = 1'b1;
    cyc();
    p1_set_bomb = 1'b0;
    cyc();
    check("full_rej", p1_reject, 1);
    cyc();
    check("full_rej_pulse", p1_reject, 0);
    check("full_num_stays", bomb_num_1, 5);
    drain();

    // Same-tile conflict, then duplicate against armed bomb
    p1_coordinate = 8'h33; p2_coordinate = 8'h33;
    p1_set_bomb = 1'b1; p2_set_bomb = 1'b1;
    cyc();
    p1_set_bomb = 1'b0; p2_set_bomb = 1'b0;
    cyc();
    check("conf_rej1", p1_reject, 0);
    check("conf_rej2", p2_reject, 1);
    cyc();
    check("conf_num1", bomb_num_1, 1);
    check("conf_num2", bomb_num_2, 0);
    p2_coordinate = 8'h33;
    p2_set_bomb = 1'b1;
    cyc();
    p2_set_bomb = 1'b0;
    cyc();
    check("dup_rej2", p2_reject, 1);
    // Different tiles in the same cycle are both accepted
    p1_coordinate = 8'h40; p2_coordinate = 8'h41;
    p1_set_bomb = 1'b1; p2_set_bomb = 1'b1;
    cyc();
    p1_set_bomb = 1'b0; p2_set_bomb = 1'b0;
    cyc();
    check("diff_rej1", p1_reject, 0);
    check("diff_rej2", p2_reject, 0);
    cyc();
    check("diff_num1", bomb_num_1, 2);
    check("diff_num2", bomb_num_2, 1);
    drain();

    // Backpressure and ordering
    req(1'b1, 8'h10, 1'b1, 8'h20);
    pulse_tick(2);
    tick = 1'b1; cyc(); tick = 1'b0;     // after T
    cyc();                               // after T+1
    check("bp_valid", explode_valid, 1);
    check("bp_coord", explode_coord, 8'h10);
    check("bp_owner", explode_owner, 0);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (explode_valid !== 1'b1 || explode_coord !== 8'h10 || explode_owner !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    explode_ready = 1'b1;
    cyc();
    check("bp_gap", explode_valid, 0);
    cyc();
    check("bp_valid2", explode_valid, 1);
    check("bp_coord2", explode_coord, 8'h20);
    check("bp_owner2", explode_owner, 1);
    cyc();
    check("bp_gap2", explode_valid, 0);
    explode_ready = 1'b0;
    cyc(); cyc();
    check("bp_num1", bomb_num_1, 0);
    check("bp_num2", bomb_num_2, 0);

    // Reset with a pending event and three armed bombs
    req(1'b1, 8'h50, 1'b0, 8'h00);
    pulse_tick(3);
    cyc();
    req(1'b1, 8'h51, 1'b1, 8'h53);
    req(1'b1, 8'h52, 1'b0, 8'h00);
    cyc();
    check("pre_rst_valid", explode_valid, 1);
    check("pre_rst_num1", bomb_num_1, 3);
    #1 rst = 1'b1;
    #1 check("async_rst_valid", explode_valid, 0);
    cyc();
    rst = 1'b0;
    check("post_rst_num1", bomb_num_1, 0);
    check("post_rst_num2", bomb_num_2, 0);
    check("post_rst_coord", explode_coord, 0);
    check("post_rst_owner", explode_owner, 0);
    seen_rej = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
      seen_rej = seen_rej | explode_valid;
    end
    check("post_rst_no_event", seen_rej, 0);
    check("post_rst_num1b", bomb_num_1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
